// File: rtl/matmul_tile_scheduler_if.sv
// ---------------------------------------------------------------------------
// matmul_tile_scheduler_if
// Bundles the two buses around the tile scheduler:
//   - command channel : cmd_valid/cmd_ready plus tile counts, base and rows
//   - systolic channel: start/clear/rows/address out, busy/done back in
// modport master : the scheduler (accepts commands, drives the systolic ctrl)
// modport slave  : its environment (command source + systolic controller)
// ---------------------------------------------------------------------------
interface matmul_tile_scheduler_if #(
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_m_tiles;
   logic [CNT_W-1:0] cmd_k_tiles;
   logic [CNT_W-1:0] cmd_acc_base;
   logic [7:0]       cmd_rows;

   logic             sys_start;
   logic [7:0]       sys_rows;
   logic [CNT_W-1:0] sys_acc_addr;
   logic             sys_acc_clear;
   logic             sys_busy;
   logic             sys_done;

   modport master (
      input  cmd_valid, cmd_m_tiles, cmd_k_tiles, cmd_acc_base, cmd_rows,
      output cmd_ready,
      output sys_start, sys_rows, sys_acc_addr, sys_acc_clear,
      input  sys_busy, sys_done
   );

   modport slave (
      output cmd_valid, cmd_m_tiles, cmd_k_tiles, cmd_acc_base, cmd_rows,
      input  cmd_ready,
      input  sys_start, sys_rows, sys_acc_addr, sys_acc_clear,
      output sys_busy, sys_done
   );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// ---------------------------------------------------------------------------
// matmul_tile_scheduler
// Runs an M x K tile loop over the 3x3 systolic controller. Each (m,k) gets
// one sys_start; k==0 is preceded by a one-cycle accumulator clear, k>0
// accumulates. Output tile m lands at acc_base+m (wraps mod 2^CNT_W).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (master)    command channel in, systolic control out
//   operands_ready  weight+input FIFOs hold a full tile
//   abort           stop issuing new tiles; the in-flight tile completes
//   sched_busy      high from command accept through the done cycle
//   sched_done      1-cycle completion pulse, sched_aborted qualifies it
//   cur_m, cur_k    current tile indices
//   perf_cycles/perf_stall  (only with TILE_SCHED_PERF_EN defined)
//
// Build option: TILE_SCHED_PERF_EN adds saturating busy/stall counters.
// ---------------------------------------------------------------------------
module matmul_tile_scheduler #(
   parameter int CNT_W    = 8,
   parameter int ROWS_DEF = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   matmul_tile_scheduler_if.master bus,
   input  logic                   operands_ready,
   input  logic                   abort,
   output logic                   sched_busy,
   output logic                   sched_done,
   output logic                   sched_aborted,
   output logic [CNT_W-1:0]       cur_m,
   output logic [CNT_W-1:0]       cur_k
`ifdef TILE_SCHED_PERF_EN
   ,
   output logic [31:0]            perf_cycles,
   output logic [31:0]            perf_stall
`endif
);

   typedef enum logic [2:0] {
      IDLE, WAIT_OPS, PRECLR, START, WAIT_BUSY, WAIT_DONE, NEXT, FINISH
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] m_tiles, k_tiles, acc_base;
   logic [CNT_W-1:0] m_cnt, k_cnt, acc_addr;
   logic [7:0]       rows;
   logic             abort_flag;

   logic accept, cmd_empty, last_k, last_m, finish_run, stop_req;

   assign accept    = bus.cmd_valid && (state == IDLE);
   assign cmd_empty = (bus.cmd_m_tiles == '0) || (bus.cmd_k_tiles == '0);
   // One extra bit so M or K of 2^CNT_W-1 cannot overflow the compare
   assign last_k    = ({1'b0, k_cnt} + (CNT_W+1)'(1)) == {1'b0, k_tiles};
   assign last_m    = ({1'b0, m_cnt} + (CNT_W+1)'(1)) == {1'b0, m_tiles};
   assign finish_run = (last_m && last_k) || abort_flag;
   assign stop_req  = abort || abort_flag;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- next state / outputs ----------------
   always_comb begin
      state_nxt         = state;
      bus.cmd_ready     = 1'b0;
      bus.sys_start     = 1'b0;
      bus.sys_acc_clear = 1'b0;
      sched_busy        = 1'b1;
      sched_done        = 1'b0;
      sched_aborted     = 1'b0;
      unique case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            sched_busy    = 1'b0;
            if (bus.cmd_valid) state_nxt = cmd_empty ? FINISH : WAIT_OPS;
         end
         WAIT_OPS: begin
            if (stop_req)            state_nxt = FINISH;
            else if (operands_ready) state_nxt = (k_cnt == '0) ? PRECLR : START;
         end
         PRECLR: begin
            // controller latches the clear while idle, so it leads start by one
            bus.sys_acc_clear = 1'b1;
            state_nxt         = START;
         end
         START: begin
            bus.sys_start = 1'b1;
            state_nxt     = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // a very short tile may finish before busy is ever observed
            if (bus.sys_done)      state_nxt = NEXT;
            else if (bus.sys_busy) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (bus.sys_done) state_nxt = NEXT;
         end
         NEXT: begin
            state_nxt = finish_run ? FINISH : WAIT_OPS;
         end
         FINISH: begin
            sched_done    = 1'b1;
            sched_aborted = abort_flag;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tiles    <= '0;
         k_tiles    <= '0;
         acc_base   <= '0;
         m_cnt      <= '0;
         k_cnt      <= '0;
         acc_addr   <= '0;
         rows       <= '0;
         abort_flag <= 1'b0;
      end else begin
         if (accept) begin
            m_tiles  <= bus.cmd_m_tiles;
            k_tiles  <= bus.cmd_k_tiles;
            acc_base <= bus.cmd_acc_base;
            m_cnt    <= '0;
            k_cnt    <= '0;
            rows     <= (bus.cmd_rows == 8'd0) ? 8'(ROWS_DEF) : bus.cmd_rows;
            if (!cmd_empty) acc_addr <= bus.cmd_acc_base;
         end

         // Counters only advance when another tile follows, so cur_m/cur_k
         // keep pointing at the last issued tile after the run ends.
         if (state == NEXT && !finish_run) begin
            if (last_k) begin
               k_cnt    <= '0;
               m_cnt    <= m_cnt + CNT_W'(1);
               acc_addr <= acc_base + m_cnt + CNT_W'(1);
            end else begin
               k_cnt <= k_cnt + CNT_W'(1);
            end
         end

         // Sticky abort: any request while a run is active ends it at the
         // next tile boundary; dropped as the FSM returns to IDLE.
         if (state == FINISH)                 abort_flag <= 1'b0;
         else if (state != IDLE && abort)     abort_flag <= 1'b1;
      end
   end

   assign bus.sys_acc_addr = acc_addr;
   assign bus.sys_rows     = rows;
   assign cur_m            = m_cnt;
   assign cur_k            = k_cnt;

`ifdef TILE_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else if (accept) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else begin
         if (sched_busy && perf_cycles != '1)
            perf_cycles <= perf_cycles + 32'd1;
         if (state == WAIT_OPS && !operands_ready && perf_stall != '1)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
